// File: rtl/vector_lsu_pkg.sv
// Shared accelerator definitions for the vector load/store unit.
// Holds the controller state encoding, element geometry and a byte-lane helper.
package vector_lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        WRITE,
        DONE
    } vlsu_state_t;

    localparam int unsigned VLSU_ELEMS_PER_REG = 4;
    localparam int unsigned VLSU_MAX_VL        = 16;

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/vector_lsu_addr_gen.sv
// Element sequencing for the vector LSU: element counter, address accumulator,
// target register / byte lane derivation and last-element flag.
module vlsu_addr_gen
    import vector_lsu_pkg::*;
#(
    parameter int unsigned MAX_VL = VLSU_MAX_VL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_advance,
    input  logic [31:0] i_base,
    input  logic [31:0] i_stride,
    input  logic        i_strided,
    input  logic [4:0]  i_vl,
    input  logic [4:0]  i_vreg,
    output logic [31:0] o_addr,
    output logic [4:0]  o_reg,
    output logic [1:0]  o_lane,
    output logic        o_last,
    output logic        o_done
);

    localparam logic [4:0] LP_MAX_VL = 5'(MAX_VL);

    logic [4:0]  r_elem;
    logic [4:0]  r_vl;
    logic [4:0]  r_vreg;
    logic [31:0] r_addr;
    logic [31:0] r_stride;
    logic [4:0]  w_vl_clamped;

    assign w_vl_clamped = (i_vl > LP_MAX_VL) ? LP_MAX_VL : i_vl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_elem   <= '0;
            r_vl     <= '0;
            r_vreg   <= '0;
            r_addr   <= '0;
            r_stride <= '0;
        end else if (i_start) begin
            r_elem   <= '0;
            r_vl     <= w_vl_clamped;
            r_vreg   <= i_vreg;
            r_addr   <= i_base;
            r_stride <= i_strided ? i_stride : 32'd1;
        end else if (i_advance) begin
            r_elem <= r_elem + 5'd1;
            r_addr <= r_addr + r_stride;
        end
    end

    // Register index wraps modulo 32 through the 5-bit add.
    assign o_reg  = r_vreg + {3'b000, r_elem[3:2]};
    assign o_lane = r_elem[1:0];
    assign o_addr = r_addr;
    assign o_last = (r_elem == r_vl - 5'd1);
    assign o_done = (r_elem >= r_vl);

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: unit-stride and strided byte-element transfers between an
// OBI data port (one outstanding transaction) and the vector register file.
module vector_lsu
    import vector_lsu_pkg::*;
#(
    parameter int unsigned VREG_W = 32,
    parameter int unsigned MAX_VL = VLSU_MAX_VL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vlsu_en,
    input  logic              vlsu_load,
    input  logic              vlsu_store,
    input  logic              vlsu_strided,
    input  logic [31:0]       base_addr,
    input  logic [31:0]       stride,
    input  logic [4:0]        vl,
    input  logic [4:0]        vreg_addr,
    output logic              vlsu_ready,
    output logic              vlsu_error,
    output logic              data_req,
    output logic              data_we,
    output logic [31:0]       data_addr,
    output logic [3:0]        data_be,
    output logic [31:0]       data_wdata,
    input  logic              data_gnt,
    input  logic              data_rvalid,
    input  logic              data_err,
    input  logic [31:0]       data_rdata,
    output logic [4:0]        vr_raddr,
    input  logic [VREG_W-1:0] vr_rdata,
    output logic              vr_we,
    output logic [4:0]        vr_waddr,
    output logic [3:0]        vr_wbe,
    output logic [VREG_W-1:0] vr_wdata
);

    vlsu_state_t r_state;
    vlsu_state_t w_next;

    logic              r_en_q;
    logic              r_is_store;
    logic [VREG_W-1:0] r_buf;
    logic [3:0]        r_mask;
    logic [4:0]        r_wreg;
    logic              r_err;

    logic              w_start;
    logic              w_advance;
    logic              w_capture;
    logic              w_set_err;
    logic [31:0]       w_addr;
    logic [4:0]        w_reg;
    logic [1:0]        w_lane;
    logic              w_last;
    logic              w_done;
    logic [7:0]        w_rbyte;
    logic [7:0]        w_sbyte;

    assign w_start = (r_state == IDLE) & vlsu_en & ~r_en_q & (vlsu_load | vlsu_store);

    vlsu_addr_gen #(
        .MAX_VL (MAX_VL)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_start),
        .i_advance (w_advance),
        .i_base    (base_addr),
        .i_stride  (stride),
        .i_strided (vlsu_strided),
        .i_vl      (vl),
        .i_vreg    (vreg_addr),
        .o_addr    (w_addr),
        .o_reg     (w_reg),
        .o_lane    (w_lane),
        .o_last    (w_last),
        .o_done    (w_done)
    );

    assign w_rbyte = data_rdata[{w_addr[1:0], 3'b000} +: 8];
    assign w_sbyte = vr_rdata[{w_lane, 3'b000} +: 8];

    always_comb begin
        w_next    = r_state;
        w_advance = 1'b0;
        w_capture = 1'b0;
        w_set_err = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = (vl == 5'd0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (data_gnt) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (data_rvalid) begin
                    if (data_err) begin
                        // Abort, but flush any load bytes already collected.
                        w_set_err = 1'b1;
                        w_next    = (!r_is_store && r_mask != 4'b0000) ? WRITE : DONE;
                    end else if (r_is_store) begin
                        w_advance = 1'b1;
                        w_next    = w_last ? DONE : REQ;
                    end else begin
                        w_advance = 1'b1;
                        w_capture = 1'b1;
                        w_next    = (w_lane == 2'd3 || w_last) ? WRITE : REQ;
                    end
                end
            end
            WRITE: begin
                w_next = (r_err || w_done) ? DONE : REQ;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_en_q     <= 1'b0;
            r_is_store <= 1'b0;
            r_buf      <= '0;
            r_mask     <= '0;
            r_wreg     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_en_q  <= vlsu_en;
            if (w_start) begin
                r_is_store <= vlsu_store;
                r_mask     <= '0;
                r_err      <= 1'b0;
            end
            if (w_capture) begin
                r_buf[{w_lane, 3'b000} +: 8] <= w_rbyte;
                r_mask[w_lane]               <= 1'b1;
                r_wreg                       <= w_reg;
            end
            if (r_state == WRITE) begin
                r_mask <= '0;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Outputs decode from state so that reset zeroes them immediately.
    always_comb begin
        vlsu_ready = (r_state == DONE);
        vlsu_error = (r_state == DONE) & r_err;
        data_req   = (r_state == REQ);
        data_we    = (r_state == REQ) & r_is_store;
        data_addr  = (r_state == REQ) ? w_addr : 32'd0;
        data_be    = (r_state == REQ) ? lane_onehot(w_addr[1:0]) : 4'b0000;
        data_wdata = ((r_state == REQ) && r_is_store) ? {4{w_sbyte}} : 32'd0;
        vr_raddr   = (r_is_store && (r_state == REQ || r_state == RESP)) ? w_reg : 5'd0;
        vr_we      = (r_state == WRITE);
        vr_waddr   = (r_state == WRITE) ? r_wreg : 5'd0;
        vr_wbe     = (r_state == WRITE) ? r_mask : 4'b0000;
        vr_wdata   = (r_state == WRITE) ? r_buf : '0;
    end

endmodule

// File: tb/tb_vector_lsu.sv
// Randomized self-checking bench for vector_lsu with an element-level reference model,
// an OBI memory responder and a register-file model.
module tb_vector_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        vlsu_en, vlsu_load, vlsu_store, vlsu_strided;
    logic [31:0] base_addr, stride;
    logic [4:0]  vl, vreg_addr;
    logic        vlsu_ready, vlsu_error;
    logic        data_req, data_we;
    logic [31:0] data_addr;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_gnt, data_rvalid, data_err;
    logic [31:0] data_rdata;
    logic [4:0]  vr_raddr;
    logic [31:0] vr_rdata;
    logic        vr_we;
    logic [4:0]  vr_waddr;
    logic [3:0]  vr_wbe;
    logic [31:0] vr_wdata;

    always #5 clk = ~clk;

    vector_lsu #(
        .VREG_W (32),
        .MAX_VL (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .vlsu_en      (vlsu_en),
        .vlsu_load    (vlsu_load),
        .vlsu_store   (vlsu_store),
        .vlsu_strided (vlsu_strided),
        .base_addr    (base_addr),
        .stride       (stride),
        .vl           (vl),
        .vreg_addr    (vreg_addr),
        .vlsu_ready   (vlsu_ready),
        .vlsu_error   (vlsu_error),
        .data_req     (data_req),
        .data_we      (data_we),
        .data_addr    (data_addr),
        .data_be      (data_be),
        .data_wdata   (data_wdata),
        .data_gnt     (data_gnt),
        .data_rvalid  (data_rvalid),
        .data_err     (data_err),
        .data_rdata   (data_rdata),
        .vr_raddr     (vr_raddr),
        .vr_rdata     (vr_rdata),
        .vr_we        (vr_we),
        .vr_waddr     (vr_waddr),
        .vr_wbe       (vr_wbe),
        .vr_wdata     (vr_wdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory and register-file models
    logic [31:0] vrf [32];
    logic [7:0]  mem [logic [31:0]];

    assign vr_rdata = vrf[vr_raddr];

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5a;
    endfunction

    // Current operation, as seen by the responder
    logic [31:0] g_base, g_eff;
    logic [4:0]  g_vreg;
    bit          g_store;
    int          g_err_elem, g_stall_elem;
    int          txn_idx, stall_left, wr_cnt;
    bit          pend, pend_err;
    logic [31:0] pend_word;
    logic [3:0]  wbe_q [$];

    function automatic logic [31:0] elem_addr(input int e);
        return g_base + 32'(e) * g_eff;
    endfunction

    function automatic logic [7:0] vrf_byte(input int e);
        logic [4:0]  r;
        logic [31:0] w;
        r = 5'(int'(g_vreg) + e / 4);
        w = vrf[r];
        return w[(e % 4) * 8 +: 8];
    endfunction

    always @(negedge clk) begin
        logic [31:0] ea;
        logic [7:0]  sb;
        data_gnt    = 1'b0;
        data_rvalid = 1'b0;
        data_err    = 1'b0;
        data_rdata  = 32'd0;
        if (reset) begin
            pend = 1'b0;
        end else if (pend) begin
            data_rvalid = 1'b1;
            data_rdata  = pend_word;
            data_err    = pend_err;
            pend        = 1'b0;
        end else if (data_req) begin
            ea = elem_addr(txn_idx);
            sb = vrf_byte(txn_idx);
            check_eq("req_addr", data_addr, ea);
            check_eq("req_we", 32'(data_we), 32'(g_store));
            check_eq("req_be", 32'(data_be), 32'(4'b0001 << ea[1:0]));
            check_eq("req_wdata", data_wdata, g_store ? {4{sb}} : 32'd0);
            if (txn_idx == g_stall_elem && stall_left > 0) begin
                stall_left--;
            end else begin
                data_gnt = 1'b1;
                if (g_store) begin
                    mem[data_addr] = data_wdata[8 * data_addr[1:0] +: 8];
                end else begin
                    for (int j = 0; j < 4; j++)
                        pend_word[8 * j +: 8] = mem_rd({data_addr[31:2], 2'(j)});
                end
                pend_err = (txn_idx == g_err_elem);
                pend     = 1'b1;
                txn_idx++;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && vr_we) begin
            for (int j = 0; j < 4; j++)
                if (vr_wbe[j]) vrf[vr_waddr][8 * j +: 8] = vr_wdata[8 * j +: 8];
            wr_cnt++;
            wbe_q.push_back(vr_wbe);
        end
    end

    task automatic check_quiet(input string tag);
        check_eq({tag, "_ready"}, 32'(vlsu_ready), 0);
        check_eq({tag, "_error"}, 32'(vlsu_error), 0);
        check_eq({tag, "_req"}, {31'd0, data_req} | {31'd0, data_we}, 0);
        check_eq({tag, "_addr"}, data_addr, 0);
        check_eq({tag, "_be"}, 32'(data_be), 0);
        check_eq({tag, "_wdata"}, data_wdata, 0);
        check_eq({tag, "_vr_we"}, 32'(vr_we), 0);
        check_eq({tag, "_vr_wbe"}, 32'(vr_wbe), 0);
        check_eq({tag, "_vr_wdata"}, vr_wdata, 0);
        check_eq({tag, "_vr_addrs"}, {22'd0, vr_waddr, vr_raddr}, 0);
    endtask

    task automatic setup_op(input bit st, input logic [31:0] base, input logic [31:0] eff,
                            input logic [4:0] vreg, input int err_e, input int stall_e,
                            input int stall_n);
        g_store      = st;
        g_base       = base;
        g_eff        = eff;
        g_vreg       = vreg;
        g_err_elem   = err_e;
        g_stall_elem = stall_e;
        stall_left   = stall_n;
        txn_idx      = 0;
        wr_cnt       = 0;
        wbe_q.delete();
    endtask

    task automatic run_op(input string tag, input bit st, input bit strd,
                          input logic [31:0] base, input logic [31:0] strd_val,
                          input logic [4:0] len, input logic [4:0] vreg,
                          input int err_e, input int stall_e, input int stall_n);
        logic [31:0] exp_vrf [32];
        logic [7:0]  exp_mem [logic [31:0]];
        logic [31:0] eff, a;
        logic [4:0]  r;
        int          nel, txns, recv, groups, lat, n;
        bit          got, got_err;

        eff    = strd ? strd_val : 32'd1;
        nel    = (len > 5'd16) ? 16 : int'(len);
        txns   = (err_e < nel) ? err_e + 1 : nel;
        recv   = (err_e < nel) ? err_e : nel;
        groups = st ? 0 : (recv + 3) / 4;
        lat    = 2 * txns + groups + ((stall_e < txns) ? stall_n : 0);

        setup_op(st, base, eff, vreg, err_e, stall_e, stall_n);
        for (int i = 0; i < 32; i++) exp_vrf[i] = vrf[i];
        for (int e = 0; e < nel; e++) begin
            a = base + 32'(e) * eff;
            r = 5'(int'(vreg) + e / 4);
            if (!st && e < recv) exp_vrf[r][(e % 4) * 8 +: 8] = mem_rd(a);
            if (st && e < txns) exp_mem[a] = vrf_byte(e);
        end

        @(negedge clk);
        vlsu_en      = 1'b1;
        vlsu_load    = !st;
        vlsu_store   = st;
        vlsu_strided = strd;
        base_addr    = base;
        stride       = strd_val;
        vl           = len;
        vreg_addr    = vreg;
        @(posedge clk);
        #1;
        n       = 0;
        got     = 1'b0;
        got_err = 1'b0;
        while (!got && n < 300) begin
            if (vlsu_ready) begin
                got     = 1'b1;
                got_err = vlsu_error;
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check_eq({tag, "_ready_seen"}, 32'(got), 1);
        check_eq({tag, "_latency"}, n, lat);
        check_eq({tag, "_error"}, 32'(got_err), 32'(err_e < nel));

        // Operands are scrambled to prove they were latched at start.
        @(negedge clk);
        vlsu_en   = 1'b0;
        base_addr = $urandom;
        vl        = 5'($urandom);
        @(posedge clk);
        #1;
        check_eq({tag, "_ready_pulse"}, 32'(vlsu_ready), 0);
        check_eq({tag, "_txns"}, txn_idx, txns);
        check_eq({tag, "_vr_writes"}, wr_cnt, groups);
        for (int i = 0; i < 32; i++) check_eq({tag, "_vrf"}, vrf[i], exp_vrf[i]);
        foreach (exp_mem[k]) check_eq({tag, "_mem"}, 32'(mem_rd(k)), 32'(exp_mem[k]));
    endtask

    initial begin
        reset        = 1'b1;
        vlsu_en      = 1'b0;
        vlsu_load    = 1'b0;
        vlsu_store   = 1'b0;
        vlsu_strided = 1'b0;
        base_addr    = '0;
        stride       = '0;
        vl           = '0;
        vreg_addr    = '0;
        pend         = 1'b0;
        setup_op(1'b0, 32'd0, 32'd1, 5'd0, 99, 99, 0);
        for (int i = 0; i < 32; i++) vrf[i] = $urandom;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        reset = 1'b0;

        // Unit-stride load into v4/v5
        for (int i = 0; i < 5; i++) mem[32'h100 + 32'(i)] = 8'(8'h11 * (i + 1));
        vrf[5] = 32'haabbcc00;
        run_op("ld5", 1'b0, 1'b0, 32'h100, 32'd0, 5'd5, 5'd4, 99, 99, 0);
        check_eq("ld5_v4", vrf[4], 32'h44332211);
        check_eq("ld5_v5", vrf[5], 32'haabbcc55);
        check_eq("ld5_wbe0", 32'(wbe_q[0]), 32'hf);
        check_eq("ld5_wbe1", 32'(wbe_q[1]), 32'h1);

        // Strided store from v2
        vrf[2] = 32'hddccbbaa;
        run_op("st_str", 1'b1, 1'b1, 32'h200, 32'd3, 5'd4, 5'd2, 99, 99, 0);
        check_eq("st_200", 32'(mem_rd(32'h200)), 32'haa);
        check_eq("st_203", 32'(mem_rd(32'h203)), 32'hbb);
        check_eq("st_206", 32'(mem_rd(32'h206)), 32'hcc);
        check_eq("st_209", 32'(mem_rd(32'h209)), 32'hdd);

        run_op("vl0", 1'b0, 1'b0, 32'h300, 32'd0, 5'd0, 5'd1, 99, 99, 0);
        run_op("stall", 1'b0, 1'b0, 32'h400, 32'd0, 5'd8, 5'd10, 99, 2, 3);
        run_op("err", 1'b0, 1'b0, 32'h500, 32'd0, 5'd4, 5'd12, 1, 99, 0);
        check_eq("err_wbe", 32'(wbe_q[0]), 32'h1);
        run_op("clamp", 1'b0, 1'b1, 32'h600, 32'hffff_fffe, 5'd31, 5'd30, 99, 99, 0);
        run_op("st_err", 1'b1, 1'b0, 32'h700, 32'd0, 5'd9, 5'd7, 5, 99, 0);

        // Reset while a load response is outstanding
        setup_op(1'b0, 32'h800, 32'd1, 5'd20, 99, 99, 0);
        @(negedge clk);
        vlsu_en   = 1'b1;
        vlsu_load = 1'b1;
        vlsu_store = 1'b0;
        vlsu_strided = 1'b0;
        base_addr = 32'h800;
        vl        = 5'd8;
        vreg_addr = 5'd20;
        for (int i = 0; i < 40 && txn_idx < 2; i++) @(negedge clk);
        check_eq("abort_granted", txn_idx, 2);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_quiet("abort");
        @(negedge clk);
        vlsu_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_no_write", wr_cnt, 0);
        check_eq("abort_no_req", txn_idx, 2);
        run_op("after_abort", 1'b0, 1'b0, 32'h800, 32'd0, 5'd6, 5'd20, 99, 99, 0);

        for (int t = 0; t < 20; t++) begin
            logic [31:0] rs;
            rs = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 16)) - 32'd8;
            run_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, rs,
                   5'($urandom_range(0, 20)), 5'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 99,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 99,
                   int'($urandom_range(1, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
